// File: rtl/fetch_unit_if.sv
// Fetch bus between the fetch unit, the instruction ROM and decode/execute.
//
// Handshake: there is no valid/ready pair on this bus. The fetch unit presents
// inst_o/inst_pc_o with inst_valid_o; decode holds it by raising stall_i,
// which keeps the word on the outputs until stall_i drops. Execute redirects
// with a one-cycle br_taken_i pulse carrying br_target_i.
//
// Signals:
//   pc_o         fetch unit -> ROM     byte address being read
//   rom_inst_i   ROM -> fetch unit     registered ROM word (1-cycle latency)
//   stall_i      decode -> fetch unit  decode not accepting
//   br_taken_i   execute -> fetch unit redirect request
//   br_target_i  execute -> fetch unit redirect byte address
//   inst_o       fetch unit -> decode  instruction
//   inst_pc_o    fetch unit -> decode  PC of inst_o
//   inst_valid_o fetch unit -> decode  inst_o is a real fetched word
//   halted_o     fetch unit -> system  PC ran past the ROM image
interface fetch_unit_if;
    logic [31:0] pc_o;
    logic [31:0] rom_inst_i;
    logic        stall_i;
    logic        br_taken_i;
    logic [31:0] br_target_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        halted_o;

    modport master (
        output pc_o,
        input  rom_inst_i,
        input  stall_i,
        input  br_taken_i,
        input  br_target_i,
        output inst_o,
        output inst_pc_o,
        output inst_valid_o,
        output halted_o
    );

    modport slave (
        input  pc_o,
        output rom_inst_i,
        output stall_i,
        output br_taken_i,
        output br_target_i,
        input  inst_o,
        input  inst_pc_o,
        input  inst_valid_o,
        input  halted_o
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for the instruction ROM.
//
// Issues one byte-address PC per cycle, pairs the ROM word returned a cycle
// later with the PC that fetched it, and hands both to decode. Supports decode
// stalls, single-cycle branch redirects from execute, and stops (halted_o)
// once the PC runs past the last ROM word.
//
// Ports:
//   clk  system clock, rising-edge
//   rst  asynchronous active-low reset
//   bus  fetch_unit_if.master (ROM address/data, decode outputs, stall/branch)
//
// Parameters:
//   MEM_DEPTH  number of 32-bit words in the ROM
//   RESET_PC   first PC fetched after reset (word-aligned)
module fetch_unit #(
    parameter int unsigned MEM_DEPTH = 7,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);

    // pc_q: address being issued; pend_q/pend_pc_q: fetch whose data is on
    // rom_inst_i this cycle; halted_q: PC left the ROM image.
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_q, pend_d;
    logic        halted_q, halted_d;

    logic        in_range;
    logic        hold;
    logic [1:0]  unused_tgt_lsb;

    // Branch targets are forced to word alignment; the low bits are dropped.
    assign unused_tgt_lsb = bus.br_target_i[1:0];

    assign in_range = (pc_q[31:2] < DEPTH_WORDS);

    // A stall only matters when there is a real word to hold, and a redirect
    // always overrides it.
    assign hold = bus.stall_i & pend_q & ~bus.br_taken_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            halted_q  <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        halted_d  = halted_q;
        if (bus.br_taken_i) begin
            // Squash the in-flight wrong-path word and restart at the target.
            pc_d     = {bus.br_target_i[31:2], 2'b00};
            pend_d   = 1'b0;
            halted_d = 1'b0;
        end else if (!hold) begin
            if (in_range) begin
                pend_d    = 1'b1;
                pend_pc_d = pc_q;
                pc_d      = pc_q + 32'd4;
            end else begin
                // Out of the image: stop issuing, keep the offending PC visible.
                pend_d   = 1'b0;
                halted_d = 1'b1;
            end
        end
    end

    // During a stall the ROM re-reads the pending word so its output is stable.
    assign bus.pc_o         = hold ? pend_pc_q : pc_q;
    assign bus.inst_o       = bus.rom_inst_i;
    assign bus.inst_pc_o    = pend_pc_q;
    assign bus.inst_valid_o = pend_q;
    assign bus.halted_o     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: registered ROM model holding the bring-up image,
// per-scenario stimulus tables, and an expected queue of {pc, instruction}.
module tb_fetch_unit;

    logic clk;
    logic rst;
    logic [31:0] rom_q;

    fetch_unit_if bus ();

    fetch_unit #(
        .MEM_DEPTH (7),
        .RESET_PC  (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bring-up program image
    function automatic logic [31:0] img(input logic [31:0] a);
        case (a)
            32'h00:  img = 32'hE3A02005;
            32'h04:  img = 32'hE3A03008;
            32'h08:  img = 32'hE0824003;
            32'h0C:  img = 32'hE0425003;
            32'h10:  img = 32'hE1520003;
            32'h14:  img = 32'hE3A06000;
            32'h18:  img = 32'h0A00002A;
            default: img = 32'h0000_0000;
        endcase
    endfunction

    // ROM with one cycle of read latency
    always @(posedge clk) rom_q <= img(bus.pc_o);
    assign bus.rom_inst_i = rom_q;

    // Driver tasks
    task automatic cycle(input logic br, input logic [31:0] tgt, input logic st);
        bus.br_taken_i  = br;
        bus.br_target_i = tgt;
        bus.stall_i     = st;
        @(negedge clk);
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, img(pc)});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.br_taken_i = 1'b0;
        bus.br_target_i = 32'h0;
        bus.stall_i = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL reset.valid got %b expected 0", bus.inst_valid_o); end
        n_cmp++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL reset.halted got %b expected 0", bus.halted_o); end
        n_cmp++; if (bus.inst_pc_o !== 32'h0) begin n_err++; $display("FAIL reset.inst_pc got %h expected 0", bus.inst_pc_o); end
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL reset.pc got %h expected 0", bus.pc_o); end
    endtask

    task automatic test_sequential();
        logic        ev [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        logic        eh [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        logic [31:0] ep [10] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h1C, 32'h1C, 32'h1C};
        logic [63:0] e;
        exp_q.delete();
        for (int p = 0; p < 28; p += 4) push_exp(32'(p));
        rst = 1'b1;
        n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL seq.pc_start got %h expected 0", bus.pc_o); end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL seq.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.halted_o !== eh[i]) begin n_err++; $display("FAIL seq.halted cyc %0d got %b expected %b", i, bus.halted_o, eh[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL seq.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL seq.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL seq.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL seq.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_halt_restart();
        logic        br [3] = '{1, 0, 0};
        logic        ev [3] = '{0, 1, 1};
        logic [31:0] ep [3] = '{32'h0, 32'h4, 32'h8};
        logic [63:0] e;
        exp_q.delete();
        push_exp(32'h0); push_exp(32'h4);
        for (int i = 0; i < 3; i++) begin
            cycle(br[i], 32'h0, 1'b0);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL restart.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL restart.halted cyc %0d got %b expected 0", i, bus.halted_o); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL restart.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL restart.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL restart.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL restart.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        logic        br [6] = '{1, 0, 0, 0, 0, 0};
        logic        st [6] = '{0, 0, 1, 1, 1, 0};
        logic        ev [6] = '{0, 1, 1, 1, 1, 1};
        logic [31:0] ep [6] = '{32'h8, 32'hC, 32'h8, 32'h8, 32'h8, 32'h10};
        logic [63:0] e;
        exp_q.delete();
        push_exp(32'h8); push_exp(32'h8); push_exp(32'h8); push_exp(32'h8); push_exp(32'hC);
        for (int i = 0; i < 6; i++) begin
            cycle(br[i], 32'h8, st[i]);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL stall.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL stall.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL stall.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL stall.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_branch();
        logic        br  [9] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [31:0] tgt [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h0, 32'h0};
        logic        ev  [9] = '{0, 1, 1, 1, 1, 1, 0, 1, 1};
        logic [31:0] ep  [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h4, 32'h8, 32'hC};
        logic [63:0] e;
        exp_q.delete();
        for (int p = 0; p <= 16; p += 4) push_exp(32'(p));
        push_exp(32'h4); push_exp(32'h8);
        for (int i = 0; i < 9; i++) begin
            cycle(br[i], tgt[i], 1'b0);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL branch.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL branch.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL branch.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL branch.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL branch.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_branch_stall();
        logic        br  [5] = '{1, 0, 1, 0, 0};
        logic [31:0] tgt [5] = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        st  [5] = '{0, 0, 1, 1, 0};
        logic        ev  [5] = '{0, 1, 0, 1, 1};
        logic [31:0] ep  [5] = '{32'h8, 32'hC, 32'h0, 32'h0, 32'h8};
        logic [63:0] e;
        exp_q.delete();
        push_exp(32'h8); push_exp(32'h0); push_exp(32'h4);
        for (int i = 0; i < 5; i++) begin
            cycle(br[i], tgt[i], st[i]);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL brstall.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL brstall.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL brstall.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL brstall.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL brstall.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_target_range();
        logic        br  [6] = '{1, 0, 0, 1, 0, 0};
        logic [31:0] tgt [6] = '{32'h9, 32'h0, 32'h0, 32'h100, 32'h0, 32'h0};
        logic        ev  [6] = '{0, 1, 1, 0, 0, 0};
        logic        eh  [6] = '{0, 0, 0, 0, 1, 1};
        logic [31:0] ep  [6] = '{32'h8, 32'hC, 32'h10, 32'h100, 32'h100, 32'h100};
        logic [63:0] e;
        exp_q.delete();
        push_exp(32'h8); push_exp(32'hC);
        for (int i = 0; i < 6; i++) begin
            cycle(br[i], tgt[i], 1'b0);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL range.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.halted_o !== eh[i]) begin n_err++; $display("FAIL range.halted cyc %0d got %b expected %b", i, bus.halted_o, eh[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL range.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL range.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL range.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL range.drain got %0d left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic        br [7] = '{1, 0, 0, 0, 0, 0, 0};
        logic        ev [7] = '{0, 1, 1, 1, 1, 1, 1};
        logic [31:0] ep [7] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h4, 32'h8};
        logic [63:0] e;
        exp_q.delete();
        for (int p = 0; p <= 12; p += 4) push_exp(32'(p));
        push_exp(32'h0); push_exp(32'h4);
        for (int i = 0; i < 7; i++) begin
            if (i == 5) begin
                // Reset lands between clock edges, with inst_pc_o = 0xC on display.
                #2 rst = 1'b0;
                #1;
                n_cmp++; if (bus.inst_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid.valid got %b expected 0", bus.inst_valid_o); end
                n_cmp++; if (bus.pc_o !== 32'h0) begin n_err++; $display("FAIL rstmid.pc got %h expected 0", bus.pc_o); end
                n_cmp++; if (bus.halted_o !== 1'b0) begin n_err++; $display("FAIL rstmid.halted got %b expected 0", bus.halted_o); end
                n_cmp++; if (bus.inst_pc_o !== 32'h0) begin n_err++; $display("FAIL rstmid.inst_pc got %h expected 0", bus.inst_pc_o); end
                @(negedge clk);
                rst = 1'b1;
            end
            cycle(br[i], 32'h0, 1'b0);
            n_cmp++; if (bus.inst_valid_o !== ev[i]) begin n_err++; $display("FAIL rstmid.valid cyc %0d got %b expected %b", i, bus.inst_valid_o, ev[i]); end
            n_cmp++; if (bus.pc_o !== ep[i]) begin n_err++; $display("FAIL rstmid.pc cyc %0d got %h expected %h", i, bus.pc_o, ep[i]); end
            if (bus.inst_valid_o === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_err++; $display("FAIL rstmid.extra cyc %0d got pc %h with empty queue", i, bus.inst_pc_o); end
                else begin
                    e = exp_q.pop_front();
                    if ({bus.inst_pc_o, bus.inst_o} !== e) begin n_err++; $display("FAIL rstmid.inst cyc %0d got %h/%h expected %h/%h", i, bus.inst_pc_o, bus.inst_o, e[63:32], e[31:0]); end
                end
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rstmid.drain got %0d left expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_halt_restart();
        test_stall();
        test_branch();
        test_branch_stall();
        test_target_range();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
